regfile_wb_arbiter: RTL
=======================

// Module: regfile_wb_arbiter
// PURPOSE
//  Sequences the single write port of the 64x32 distributed register file.
//  Round-robin arbitration between NREQ write-back requesters (ALU, load unit, FPU)
//  via valid/ready handshakes; one registered write per cycle.
//  Tracks a per-register busy scoreboard (set at issue, cleared at write-back)
//  for the decode stage's hazard checks.
// PARAMETERS
//  NREQ      3   number of write-back requesters (index 0 = ALU, 1 = load, 2 = FPU)
//  ADDR_W    6   register address width (2**ADDR_W entries)
//  DATA_W    32  write data width
//  ZERO_REG  1   1: address 0 is never marked busy; writes to it are accepted but dropped
// PORTS
//  clk         in   1              clock, all state on posedge
//  rst         in   1              asynchronous reset, active-high
//  req_valid   in   NREQ           requester i holds a write-back
//  req_addr    in   NREQ*ADDR_W    dest address; slice i = [i*ADDR_W +: ADDR_W]
//  req_data    in   NREQ*DATA_W    write data; slice i = [i*DATA_W +: DATA_W]
//  req_ready   out  NREQ           one-hot grant; transfer when valid & ready
//  issue_valid in   1              an instruction with a destination issues this cycle
//  issue_dst   in   ADDR_W         its destination register
//  flush       in   1              pipeline flush: clear scoreboard, block grants
//  chk_a_addr  in   ADDR_W         source-operand address A to check
//  chk_b_addr  in   ADDR_W         source-operand address B to check
//  chk_a_busy  out  1              busy[chk_a_addr], combinational
//  chk_b_busy  out  1              busy[chk_b_addr], combinational
//  rf_we       out  1              register-file write enable (registered)
//  rf_wa       out  ADDR_W         register-file write address (registered)
//  rf_wd       out  DATA_W         register-file write data (registered)
//  busy_cnt    out  ADDR_W+1       number of set busy bits (registered)
// BEHAVIOUR
//  Reset: busy[] = 0, rr_ptr = NREQ-1, rf_we = 0, rf_wa = 0, rf_wd = 0, busy_cnt = 0.
//   req_ready = 0 while rst is high.
//  Arbitration (combinational):
//   - Search order rr_ptr+1, rr_ptr+2, ... mod NREQ; the first valid requester wins.
//   - req_ready is one-hot or zero; ready is never raised for an invalid requester.
//   - flush = 1 forces req_ready = 0.
//   - On a transfer, rr_ptr <= granted index. With no transfer, rr_ptr holds.
//   - Requesters hold addr/data stable until accepted; ready may change while valid is low.
//  Write stage (latency 1):
//   - Transfer in cycle N: rf_we = 1 with that addr/data in cycle N+1; the RF commits at the end of N+1.
//   - No transfer (or ZERO_REG and addr = 0): rf_we = 0 in N+1; rf_wa/rf_wd hold.
//   - Throughput: one write per cycle; back-to-back grants legal.
//  Scoreboard (updated on posedge):
//   - Set: issue_valid -> busy[issue_dst] <= 1, except addr 0 when ZERO_REG.
//   - Clear: transfer of addr X in cycle N -> busy[X] <= 0 at the end of N,
//     so chk_*_busy for X reads 0 from N+1. The RF data is readable from N+2.
//     Decode must not read X in N+1 without bypassing rf_wd.
//   - Simultaneous set and clear of the same address: set wins (newer producer), bit stays 1.
//   - Set of an already-busy bit: stays 1, no error. Clear of an idle bit: no effect.
//   - flush: all busy <= 0. It overrides an issue_valid in the same cycle.
//     A write issued in the flush cycle's previous cycle still completes on rf_we.
//   - busy_cnt is the popcount of next-state busy[], registered with it; range 0..2**ADDR_W-1.
//  Reset mid-operation: async clear of everything above; a pending rf_we is dropped immediately.
// TESTING
//  1. Reset, then req_valid = 3'b111, addrs 5/6/7, data A/B/C held: grants 0,1,2,0 in successive cycles.
//     rf_we/wa/wd show (5,A),(6,B),(7,C) one cycle after each grant.
//  2. issue_valid, dst = 9: chk_a_busy = 1 next cycle, busy_cnt = 1.
//     Then load writes 9: chk_a_busy = 0 the cycle after the transfer, busy_cnt = 0.
//  3. issue_dst = 12 and a transfer to 12 in the same cycle: busy[12] stays 1, busy_cnt unchanged.
//  4. issue_valid dst = 0 and a write to 0 (ZERO_REG = 1): chk busy stays 0.
//     req_ready asserts, rf_we stays 0.
//  5. Mark regs 1..10 busy, then flush with req_valid = 3'b010: req_ready = 0.
//     busy_cnt = 0 next cycle, all chk busy = 0.
//  6. Assert rst while rf_we = 1 and busy_cnt = 4: rf_we = 0 and busy_cnt = 0 immediately.
//     After release the first grant goes to requester 0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Write-port sequencer for the 64x32 register file: round-robin arbitration
// of write-back requesters, one registered write per cycle, and a per-register
// busy scoreboard feeding the decode stage's hazard checks.
module regfile_wb_arbiter #(
  parameter int NREQ     = 3,
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 32,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     issue_valid,
  input  logic [ADDR_W-1:0]        issue_dst,
  input  logic                     flush,
  input  logic [ADDR_W-1:0]        chk_a_addr,
  input  logic [ADDR_W-1:0]        chk_b_addr,
  output logic                     chk_a_busy,
  output logic                     chk_b_busy,
  output logic                     rf_we,
  output logic [ADDR_W-1:0]        rf_wa,
  output logic [DATA_W-1:0]        rf_wd,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int NENT  = 1 << ADDR_W;
  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NENT-1:0]   busy;
  logic [NENT-1:0]   busy_nxt;
  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  gnt_idx;
  logic [NREQ-1:0]   grant;
  logic              arb_found;
  int                arb_idx;
  logic              xfer;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] gnt_data;
  logic              gnt_drop;
  logic [ADDR_W:0]   cnt_nxt;

  // Round-robin search starting just after the last winner; flush or reset
  // suppresses every grant so nothing is accepted while the pipe is unwinding.
  always_comb begin
    grant     = '0;
    gnt_idx   = '0;
    arb_found = 1'b0;
    arb_idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      arb_idx = (int'(rr_ptr) + k) % NREQ;
      if (!arb_found && req_valid[arb_idx]) begin
        arb_found       = 1'b1;
        grant[arb_idx]  = 1'b1;
        gnt_idx         = PTR_W'(arb_idx);
      end
    end
    if (flush || rst) begin
      grant = '0;
    end
  end

  assign req_ready = grant;
  assign xfer      = |grant;
  assign gnt_addr  = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
  assign gnt_data  = req_data[int'(gnt_idx)*DATA_W +: DATA_W];
  assign gnt_drop  = (ZERO_REG != 0) && (gnt_addr == '0);

  assign chk_a_busy = busy[chk_a_addr];
  assign chk_b_busy = busy[chk_b_addr];

  // Next scoreboard state: clear on write-back, then set on issue so a new
  // producer for the same register wins, and flush wipes everything last.
  always_comb begin
    busy_nxt = busy;
    if (xfer) begin
      busy_nxt[gnt_addr] = 1'b0;
    end
    if (issue_valid && !((ZERO_REG != 0) && (issue_dst == '0))) begin
      busy_nxt[issue_dst] = 1'b1;
    end
    if (flush) begin
      busy_nxt = '0;
    end
  end

  // Popcount of the next scoreboard so busy_cnt tracks busy in the same cycle.
  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < NENT; i++) begin
      cnt_nxt = cnt_nxt + (ADDR_W+1)'(busy_nxt[i]);
    end
  end

  // State update: scoreboard, arbitration pointer and the registered write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= '0;
      busy_cnt <= '0;
      rr_ptr   <= PTR_W'(NREQ-1);
      rf_we    <= 1'b0;
      rf_wa    <= '0;
      rf_wd    <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
      if (xfer) begin
        rr_ptr <= gnt_idx;
      end
      rf_we <= xfer && !gnt_drop;
      if (xfer && !gnt_drop) begin
        rf_wa <= gnt_addr;
        rf_wd <= gnt_data;
      end
    end
  end

endmodule
